// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt pipeline sequencer.
package int_pkg;

  // Sequencer states; the encoding is visible on waveforms, so keep it fixed.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    HANDLER = 2'd2,
    RESTORE = 2'd3
  } state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_1000;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;
  localparam int          CAUSE_W        = 3;

  // Handler vector for a line index; the arithmetic wraps at 32 bits.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [CAUSE_W-1:0] idx);
    return base + ({29'd0, idx} * stride);
  endfunction

endpackage

// File: rtl/int_pipe_sequencer_if.sv
// Request/strobe bundle between the pipeline control and the interrupt sequencer.
interface int_pipe_sequencer_if import int_pkg::*; #(
  parameter int NUM_IRQ = 4
) ();

  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               int_en;
  logic               pipe_busy;
  logic [31:0]        EX_PC;
  logic               eret;

  logic               INT_detected;
  logic               INT_restore;
  logic               EX_Flush;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               in_service;
  logic [31:0]        epc;
  logic [CAUSE_W-1:0] cause;
  logic               timeout_err;

  // Pipeline / interrupt-source side.
  modport master (
    output irq, irq_mask, int_en, pipe_busy, EX_PC, eret,
    input  INT_detected, INT_restore, EX_Flush, redirect_valid, redirect_pc,
           irq_ack, in_service, epc, cause, timeout_err
  );

  // Sequencer side.
  modport slave (
    input  irq, irq_mask, int_en, pipe_busy, EX_PC, eret,
    output INT_detected, INT_restore, EX_Flush, redirect_valid, redirect_pc,
           irq_ack, in_service, epc, cause, timeout_err
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of pending wins.
module irq_prio_enc import int_pkg::*; #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] pending,
  output logic               any,
  output logic [CAUSE_W-1:0] idx,
  output logic [NUM_IRQ-1:0] onehot
);

  localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

  // Isolate the lowest set bit, then fold its position into a binary index.
  always_comb begin
    any    = |pending;
    onehot = pending & (~pending + ONE);
    idx    = {CAUSE_W{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      idx = idx | (onehot[i] ? CAUSE_W'(i) : {CAUSE_W{1'b0}});
    end
  end

endmodule

// File: rtl/int_pipe_sequencer.sv
// Interrupt sequencer: picks a line, pulses save/flush with the vector redirect,
// waits for eret (or the watchdog) and then pulses restore with the EPC redirect.
module int_pipe_sequencer import int_pkg::*; #(
  parameter int          NUM_IRQ    = 4,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
  parameter int          TIMEOUT    = 1024
) (
  input logic                 clk,
  input logic                 reset,
  int_pipe_sequencer_if.slave bus
);

  localparam int             WDW     = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_set_timeout;
  logic [NUM_IRQ-1:0] w_pending;
  logic               w_any;
  logic [CAUSE_W-1:0] w_idx;
  logic [NUM_IRQ-1:0] w_onehot;

  logic [WDW-1:0]     r_wdog;
  logic [31:0]        r_epc;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_timeout_err;
  logic               r_int_detected;
  logic               r_int_restore;
  logic               r_ex_flush;
  logic               r_redirect_valid;
  logic [31:0]        r_redirect_pc;
  logic [NUM_IRQ-1:0] r_irq_ack;
  logic               r_in_service;

  assign w_pending = bus.irq & ~bus.irq_mask;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .pending (w_pending),
    .any     (w_any),
    .idx     (w_idx),
    .onehot  (w_onehot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; eret takes precedence over watchdog expiry.
  always_comb begin
    w_next        = r_state;
    w_set_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.int_en && w_any && !bus.pipe_busy) begin
          w_next = SAVE;
        end else begin
          w_next = IDLE;
        end
      end
      SAVE: begin
        w_next = HANDLER;
      end
      HANDLER: begin
        if (bus.eret) begin
          w_next = RESTORE;
        end else if (r_wdog == WD_LAST) begin
          w_next        = RESTORE;
          w_set_timeout = 1'b1;
        end else begin
          w_next = HANDLER;
        end
      end
      RESTORE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Cause latch at entry, EPC capture in SAVE, handler watchdog, sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cause       <= {CAUSE_W{1'b0}};
      r_epc         <= 32'd0;
      r_wdog        <= {WDW{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_next == SAVE) begin
        r_cause <= w_idx;
      end
      if (r_state == SAVE) begin
        r_epc  <= bus.EX_PC;
        r_wdog <= {WDW{1'b0}};
      end else if (r_state == HANDLER) begin
        r_wdog <= r_wdog + WDW'(1);
      end
      if (w_set_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Strobes are registered from the next state so they are high exactly
  // while the FSM sits in the corresponding state, with no decode glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_detected   <= 1'b0;
      r_ex_flush       <= 1'b0;
      r_int_restore    <= 1'b0;
      r_in_service     <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_irq_ack        <= {NUM_IRQ{1'b0}};
    end else begin
      r_int_detected   <= (w_next == SAVE);
      r_ex_flush       <= (w_next == SAVE);
      r_int_restore    <= (w_next == RESTORE);
      r_in_service     <= (w_next == HANDLER);
      r_redirect_valid <= (w_next == SAVE) || (w_next == RESTORE);
      if (w_next == SAVE) begin
        // Entry is only possible from IDLE, so the encoder output is the cause.
        r_irq_ack     <= w_onehot;
        r_redirect_pc <= vec_addr(VEC_BASE, VEC_STRIDE, w_idx);
      end else if (w_next == RESTORE) begin
        // EPC was written at least one cycle earlier, on leaving SAVE.
        r_irq_ack     <= {NUM_IRQ{1'b0}};
        r_redirect_pc <= r_epc;
      end else begin
        r_irq_ack     <= {NUM_IRQ{1'b0}};
        r_redirect_pc <= 32'd0;
      end
    end
  end

  assign bus.INT_detected   = r_int_detected;
  assign bus.INT_restore    = r_int_restore;
  assign bus.EX_Flush       = r_ex_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.irq_ack        = r_irq_ack;
  assign bus.in_service     = r_in_service;
  assign bus.epc            = r_epc;
  assign bus.cause          = r_cause;
  assign bus.timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_int_pipe_sequencer.sv
// Self-checking bench for int_pipe_sequencer: directed table, corner sequences,
// and randomized transactions against a transaction-level reference.
module tb_int_pipe_sequencer;
  import int_pkg::*;

  localparam int T = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int_pipe_sequencer_if #(.NUM_IRQ(4)) bus ();

  int_pipe_sequencer #(
    .NUM_IRQ(4), .VEC_BASE(32'h0000_1000), .VEC_STRIDE(32'h0000_0010), .TIMEOUT(T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit model_terr;

  typedef struct {
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic        en;
    int          busy;
    int          hlen;
    bit          entry;
    logic [2:0]  cause;
    logic [31:0] vec;
    bit          terr;
  } vec_t;

  vec_t tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, 32'({bus.INT_detected, bus.INT_restore, bus.EX_Flush, bus.redirect_valid,
                 bus.in_service, bus.irq_ack}), 32'd0);
  endtask

  // Reference: arbitration rule applied directly to the request vectors.
  function automatic void model(input logic [3:0] irq_v, input logic [3:0] mask_v,
                                input logic en_v, output bit entry,
                                output logic [2:0] cause, output logic [31:0] vec);
    logic [3:0] p;
    p     = irq_v & ~mask_v;
    entry = en_v && (p != 4'd0);
    cause = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (p[i]) cause = 3'(i);
    end
    vec = 32'h0000_1000 + 32'(cause) * 32'h0000_0010;
  endfunction

  // One full service attempt from IDLE back to IDLE, checked cycle by cycle.
  task automatic run_txn(input string nm, input logic [3:0] irq_v, input logic [3:0] mask_v,
                         input logic en_v, input int busy, input int hlen,
                         input bit exp_entry, input logic [2:0] exp_cause,
                         input logic [31:0] exp_vec, input bit exp_terr,
                         input logic [31:0] epc_v);
    int n;
    bus.irq       = irq_v;
    bus.irq_mask  = mask_v;
    bus.int_en    = en_v;
    bus.pipe_busy = (busy > 0);
    bus.eret      = 1'b0;
    bus.EX_PC     = $urandom;
    for (int c = 0; c < busy; c++) begin
      step();
      chk({nm, ":busy_hold"}, 32'(bus.INT_detected), 32'd0);
    end
    bus.pipe_busy = 1'b0;
    if (!exp_entry) begin
      for (int c = 0; c < 3; c++) begin
        bus.eret = 1'($urandom_range(0, 1));
        step();
        chk_quiet({nm, ":no_entry"});
      end
      bus.eret = 1'b0;
      bus.irq  = 4'd0;
      return;
    end
    step();
    chk({nm, ":save_strobes"}, 32'({bus.INT_detected, bus.EX_Flush, bus.redirect_valid,
                                    bus.INT_restore, bus.in_service}), 32'b11100);
    chk({nm, ":save_ack"}, 32'(bus.irq_ack), 32'd1 << exp_cause);
    chk({nm, ":save_vec"}, bus.redirect_pc, exp_vec);
    chk({nm, ":save_cause"}, 32'(bus.cause), 32'(exp_cause));
    bus.EX_PC = epc_v;
    n = (hlen <= T) ? hlen : T;
    for (int h = 1; h <= n; h++) begin
      step();
      chk({nm, ":handler"}, 32'({bus.in_service, bus.INT_detected, bus.INT_restore,
                                 bus.redirect_valid}), 32'b1000);
      bus.EX_PC    = $urandom;
      bus.irq      = 4'($urandom);
      bus.irq_mask = 4'($urandom);
      bus.eret     = (h == hlen);
    end
    step();
    chk({nm, ":restore_strobes"}, 32'({bus.INT_restore, bus.redirect_valid, bus.INT_detected,
                                       bus.EX_Flush, bus.in_service}), 32'b11000);
    chk({nm, ":restore_pc"}, bus.redirect_pc, epc_v);
    chk({nm, ":epc"}, bus.epc, epc_v);
    chk({nm, ":timeout_err"}, 32'(bus.timeout_err), 32'(exp_terr));
    chk({nm, ":cause_held"}, 32'(bus.cause), 32'(exp_cause));
    bus.eret = 1'b0;
    bus.irq  = 4'd0;
    step();
    chk_quiet({nm, ":back_idle"});
  endtask

  initial begin
    bit          e;
    logic [2:0]  c;
    logic [31:0] v;
    logic [3:0]  ri, rm;
    logic        ren;
    int          rb, rh;

    //          irq      mask     en    busy hlen entry cause vec            terr
    tbl[0] = '{4'b0100, 4'b0000, 1'b1, 0,   2,   1'b1, 3'd2, 32'h0000_1020, 1'b0};
    tbl[1] = '{4'b1010, 4'b0010, 1'b1, 0,   1,   1'b1, 3'd3, 32'h0000_1030, 1'b0};
    tbl[2] = '{4'b1010, 4'b0000, 1'b1, 0,   3,   1'b1, 3'd1, 32'h0000_1010, 1'b0};
    tbl[3] = '{4'b0001, 4'b0000, 1'b1, 3,   1,   1'b1, 3'd0, 32'h0000_1000, 1'b0};
    tbl[4] = '{4'b0001, 4'b0000, 1'b0, 0,   1,   1'b0, 3'd0, 32'h0000_0000, 1'b0};
    tbl[5] = '{4'b1111, 4'b1111, 1'b1, 1,   1,   1'b0, 3'd0, 32'h0000_0000, 1'b0};
    tbl[6] = '{4'b1000, 4'b0000, 1'b1, 0,   8,   1'b1, 3'd3, 32'h0000_1030, 1'b0};
    tbl[7] = '{4'b0010, 4'b0000, 1'b1, 0,   20,  1'b1, 3'd1, 32'h0000_1010, 1'b1};

    reset         = 1'b1;
    bus.irq       = 4'd0;
    bus.irq_mask  = 4'd0;
    bus.int_en    = 1'b0;
    bus.pipe_busy = 1'b0;
    bus.EX_PC     = 32'd0;
    bus.eret      = 1'b0;
    step();
    step();
    chk_quiet("reset_strobes");
    chk("reset_epc", bus.epc, 32'd0);
    chk("reset_cause", 32'(bus.cause), 32'd0);
    chk("reset_terr", 32'(bus.timeout_err), 32'd0);
    reset = 1'b0;
    step();

    for (int r = 0; r < 8; r++) begin
      run_txn($sformatf("tbl%0d", r), tbl[r].irq, tbl[r].mask, tbl[r].en, tbl[r].busy,
              tbl[r].hlen, tbl[r].entry, tbl[r].cause, tbl[r].vec, tbl[r].terr,
              (r == 0) ? 32'h0000_0040 : 32'($urandom));
    end

    // Back-to-back: request held through RESTORE re-enters two cycles later.
    bus.irq      = 4'b0001;
    bus.irq_mask = 4'd0;
    bus.int_en   = 1'b1;
    step();
    chk("b2b_save1", 32'(bus.INT_detected), 32'd1);
    step();
    chk("b2b_handler", 32'(bus.in_service), 32'd1);
    bus.eret = 1'b1;
    step();
    chk("b2b_restore", 32'(bus.INT_restore), 32'd1);
    bus.eret = 1'b0;
    step();
    chk("b2b_gap", 32'({bus.INT_detected, bus.in_service, bus.INT_restore}), 32'd0);
    step();
    chk("b2b_resave", 32'({bus.INT_detected, bus.irq_ack}), 32'b10001);
    chk("b2b_terr_sticky", 32'(bus.timeout_err), 32'd1);
    step();
    bus.eret = 1'b1;
    bus.irq  = 4'd0;
    step();
    chk("b2b_restore2", 32'(bus.INT_restore), 32'd1);
    bus.eret = 1'b0;
    step();
    chk_quiet("b2b_idle");

    // Reset while in HANDLER: everything clears, no restore pulse follows.
    bus.irq = 4'b0100;
    step();
    chk("rmid_save", 32'(bus.INT_detected), 32'd1);
    bus.EX_PC = 32'h1234_5678;
    step();
    chk("rmid_epc", bus.epc, 32'h1234_5678);
    step();
    chk("rmid_in_service", 32'(bus.in_service), 32'd1);
    reset   = 1'b1;
    bus.irq = 4'd0;
    step();
    chk_quiet("rmid_strobes");
    chk("rmid_epc_clr", bus.epc, 32'd0);
    chk("rmid_terr_clr", 32'(bus.timeout_err), 32'd0);
    chk("rmid_cause_clr", 32'(bus.cause), 32'd0);
    reset = 1'b0;
    step();
    chk_quiet("rmid_after1");
    step();
    chk_quiet("rmid_after2");

    // Randomized transactions against the reference.
    model_terr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ri  = 4'($urandom);
      rm  = 4'($urandom & $urandom);
      ren = ($urandom_range(0, 3) != 0);
      rb  = $urandom_range(0, 3);
      rh  = $urandom_range(1, 11);
      model(ri, rm, ren, e, c, v);
      if (e && rh > T) model_terr = 1'b1;
      run_txn($sformatf("rnd%0d", i), ri, rm, ren, rb, rh, e, c, v, model_terr, 32'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/int_pipe_sequencer.md
Name: int_pipe_sequencer

Overview:
- Interrupt sequencer for the EX/MEM pipeline register and the fetch redirect path.
- Arbitrates NUM_IRQ level-sensitive interrupt lines by fixed priority and captures the EX-stage PC as the EPC.
- Drives the one-cycle save/clear and restore strobes (INT_detected / INT_restore) consumed by the EX/MEM register, plus EX_Flush and the handler-vector redirect.
- Sits beside the hazard unit and feeds the NPC mux.

Parameters:
- NUM_IRQ, 4: number of interrupt request lines (1..8).
- VEC_BASE, 32'h0000_1000: handler vector base address.
- VEC_STRIDE, 32'h0000_0010: byte spacing between per-line vectors.
- TIMEOUT, 1024: maximum HANDLER cycles before a forced restore (must be ≥ 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- irq  in  NUM_IRQ  level interrupt requests.
- irq_mask  in  NUM_IRQ  1 = line masked.
- int_en  in  1  global interrupt enable.
- pipe_busy  in  1  a multi-cycle memory op is in flight; defer interrupt entry.
- EX_PC  in  32  PC of the instruction currently in EX.
- eret  in  1  handler-return strobe from decode.
- INT_detected  out  1  one-cycle pulse: EX/MEM saves its contents and clears.
- INT_restore  out  1  one-cycle pulse: EX/MEM reloads its saved contents.
- EX_Flush  out  1  flush ID/EX, asserted with INT_detected.
- redirect_valid  out  1  NPC mux selects redirect_pc this cycle.
- redirect_pc  out  32  vector address or EPC.
- irq_ack  out  NUM_IRQ  one-hot acknowledge of the serviced line, one cycle.
- in_service  out  1  FSM in HANDLER.
- epc  out  32  captured EX_PC.
- cause  out  3  index of the serviced line.
- timeout_err  out  1  sticky: the watchdog forced a restore.

Behaviour:
- Reset, synchronous, highest priority:
  - state = IDLE.
  - epc = 0, cause = 0, wdog = 0, timeout_err = 0.
  - All pulse outputs are 0.
- pending = irq & ~irq_mask. The winner is the lowest set index (line 0 is highest priority).
- IDLE:
  - If int_en & |pending & !pipe_busy: latch cause = winner, then go to SAVE.
  - Otherwise stay in IDLE.
  - eret in IDLE is ignored.
- SAVE (exactly 1 cycle):
  - INT_detected = 1, EX_Flush = 1, irq_ack = onehot(cause).
  - epc <= EX_PC.
  - redirect_valid = 1, redirect_pc = VEC_BASE + cause*VEC_STRIDE (32-bit wrap).
  - wdog <= 0. Next state: HANDLER.
- HANDLER:
  - in_service = 1. New or changed irq is ignored (no nesting); mask changes are ignored.
  - wdog increments each cycle.
  - If eret: go to RESTORE.
  - Else if wdog == TIMEOUT-1: set timeout_err, go to RESTORE.
  - If eret and timeout occur in the same cycle, eret wins and timeout_err is unchanged.
- RESTORE (exactly 1 cycle):
  - INT_restore = 1, redirect_valid = 1, redirect_pc = epc.
  - Next state: IDLE.
  - An irq still pending on return may be accepted the following cycle, giving a minimum 1 IDLE cycle between services.
- Output encoding and exclusivity:
  - All strobes are registered-state decoded (Moore): valid in the cycle the FSM is in the named state.
  - INT_detected and INT_restore are never high together.
- Reset mid-operation: any state returns to IDLE next edge. A SAVE without a matching RESTORE is acceptable because the EX/MEM register is also reset.
- pipe_busy is sampled only in IDLE.
- timeout_err clears only on reset.

Decomposition:
- Shared package int_pkg:
  - State enum: IDLE=2'd0, SAVE=2'd1, HANDLER=2'd2, RESTORE=2'd3.
  - VEC_BASE and VEC_STRIDE defaults.
  - Cause width constant (3).
- One sub-module irq_prio_enc (NUM_IRQ):
  - Input pending.
  - Outputs any, idx[2:0] and onehot[NUM_IRQ-1:0].
  - Purely combinational, lowest index wins.

Test Plan:
- Basic entry and return:
  - Stimulus: reset, int_en=1, mask=0, EX_PC=32'h0000_0040, irq=4'b0100.
  - Response: next cycle SAVE, INT_detected=EX_Flush=1, irq_ack=4'b0100, redirect_pc=32'h0000_1020; epc=32'h40 after.
  - Then eret → one RESTORE cycle with INT_restore=1 and redirect_pc=32'h40, then IDLE.
- Priority and mask:
  - Stimulus: irq=4'b1010, mask=4'b0010.
  - Response: cause=3, redirect_pc=32'h0000_1030.
  - With mask=0, cause=1 and redirect_pc=32'h0000_1010.
- Deferral:
  - Stimulus: irq=4'b0001 with pipe_busy=1 for 3 cycles, then 0.
  - Response: INT_detected rises the cycle after pipe_busy falls.
  - Stimulus: int_en=0 → no entry.
- Watchdog:
  - Stimulus: TIMEOUT=8, no eret.
  - Response: RESTORE occurs 8 cycles after HANDLER entry and timeout_err=1 persists.
  - Stimulus: eret on the same cycle as expiry.
  - Response: timeout_err stays 0.
- No nesting, back-to-back:
  - Stimulus: a new irq during HANDLER.
  - Response: ignored.
  - Stimulus: irq held through RESTORE.
  - Response: re-entry SAVE exactly 2 cycles after RESTORE.
- Reset mid-HANDLER:
  - Stimulus: assert reset while in HANDLER.
  - Response: next edge all outputs 0, in_service=0, epc=0, no INT_restore pulse.
